// File: rtl/uart_pingpong_engine_if.sv
// UART-side handshake bundle for the ping-pong engine: transmit write port and receive strobe port.
interface uart_pingpong_engine_if #(
   parameter int unsigned DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] TX_DATA;
   logic                  TX_WE;
   logic                  TX_READY;
   logic [DATA_WIDTH-1:0] RX_DATA;
   logic                  RX_EN;

   // Engine side drives the transmitter and consumes the receiver.
   modport master (
      output TX_DATA,
      output TX_WE,
      input  TX_READY,
      input  RX_DATA,
      input  RX_EN
   );

   // UART side accepts transmit words and delivers received words.
   modport slave (
      input  TX_DATA,
      input  TX_WE,
      output TX_READY,
      output RX_DATA,
      output RX_EN
   );

endinterface

// File: rtl/uart_pingpong_engine.sv
// Ping-pong traffic engine for one end of a UART link. Sends an incrementing word sequence,
// checks every echo from the peer, detects receive timeouts and reports pass/fail.
module uart_pingpong_engine #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           ROLE       = 0,
   parameter logic [DATA_WIDTH-1:0] START_VAL  = DATA_WIDTH'(8'h61),
   parameter int unsigned           NUM_XFER   = 16,
   parameter int unsigned           TIMEOUT    = 100000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   uart_pingpong_engine_if.master uart,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   PASS,
   output logic                   TIMED_OUT,
   output logic [15:0]            ERR_CNT,
   output logic [15:0]            XFER_CNT
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND    = 2'd1;
   localparam logic [1:0] ST_WAIT_RX = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);
   localparam logic [15:0]           NUM_XFER_W = 16'(NUM_XFER);
   // Wraps when TIMEOUT is 0, but the compare is gated off in that case.
   localparam logic [31:0]           TIMER_LAST = 32'(TIMEOUT - 1);
   localparam bit                    IS_RESP    = (ROLE == 1);

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] pending_q, pending_d;
   logic [DATA_WIDTH-1:0] last_sent_q, last_sent_d;
   logic [DATA_WIDTH-1:0] expected_q, expected_d;
   logic [31:0]           timer_q, timer_d;
   logic                  tx_we_q, tx_we_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic                  timed_out_q, timed_out_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [15:0]           xfer_cnt_q, xfer_cnt_d;

   logic [15:0]           err_inc;
   logic [15:0]           xfer_inc;

   assign err_inc  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
   assign xfer_inc = xfer_cnt_q + 16'd1;

   // Next-state logic: protocol sequencing, echo checking and timeout.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      last_sent_d = last_sent_q;
      expected_d  = expected_q;
      timer_d     = timer_q;
      tx_we_d     = 1'b0;
      timed_out_d = timed_out_q;
      err_cnt_d   = err_cnt_q;
      xfer_cnt_d  = xfer_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               if (IS_RESP) begin
                  expected_d = START_VAL;
                  timer_d    = '0;
                  state_d    = ST_WAIT_RX;
               end else begin
                  pending_d = START_VAL;
                  state_d   = ST_SEND;
               end
            end
         end

         ST_SEND: begin
            // A word arriving while we still owe a transmit is an overrun; it is dropped.
            if (uart.RX_EN) begin
               err_cnt_d = err_inc;
            end
            if (uart.TX_READY) begin
               tx_we_d     = 1'b1;
               last_sent_d = pending_q;
               xfer_cnt_d  = xfer_inc;
               expected_d  = pending_q + ONE;
               if (IS_RESP && (xfer_inc == NUM_XFER_W)) begin
                  state_d = ST_DONE;
               end else begin
                  timer_d = '0;
                  state_d = ST_WAIT_RX;
               end
            end
         end

         ST_WAIT_RX: begin
            if (uart.RX_EN) begin
               if (uart.RX_DATA != expected_q) begin
                  err_cnt_d = err_inc;
               end
               // The reply is always built from the received word, so a mismatch resyncs.
               if (!IS_RESP && (xfer_cnt_q == NUM_XFER_W)) begin
                  state_d = ST_DONE;
               end else begin
                  pending_d = uart.RX_DATA + ONE;
                  state_d   = ST_SEND;
               end
            end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
               timed_out_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end

         default: begin
            state_d = ST_DONE;
         end
      endcase

      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_cnt_d == 16'd0) && !timed_out_d;
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         last_sent_q <= '0;
         expected_q  <= START_VAL;
         timer_q     <= '0;
         tx_we_q     <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timed_out_q <= 1'b0;
         err_cnt_q   <= '0;
         xfer_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         last_sent_q <= last_sent_d;
         expected_q  <= expected_d;
         timer_q     <= timer_d;
         tx_we_q     <= tx_we_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timed_out_q <= timed_out_d;
         err_cnt_q   <= err_cnt_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   // TX_DATA holds the last transmitted word, which is exactly last_sent.
   assign uart.TX_DATA = last_sent_q;
   assign uart.TX_WE   = tx_we_q;
   assign BUSY         = (state_q == ST_SEND) || (state_q == ST_WAIT_RX);
   assign DONE         = done_q;
   assign PASS         = pass_q;
   assign TIMED_OUT    = timed_out_q;
   assign ERR_CNT      = err_cnt_q;
   assign XFER_CNT     = xfer_cnt_q;

endmodule

// File: tb/tb_uart_pingpong_engine.sv
// Testbench: initiator/responder pairs joined by a 10-cycle loopback, with a TX scoreboard.
module tb_uart_pingpong_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic rdy_a_i = 1'b1;
   logic corrupt = 1'b0;
   logic inj = 1'b0;

   // Index: 0 A.init, 1 A.resp, 2 B.init, 3 B.resp, 4 C.init, 5 C.resp (held in reset)
   logic        busy [6];
   logic        done [6];
   logic        pass [6];
   logic        tout [6];
   logic [15:0] err  [6];
   logic [15:0] xfer [6];

   uart_pingpong_engine_if #(.DATA_WIDTH(8)) if_ia ();
   uart_pingpong_engine_if #(.DATA_WIDTH(8)) if_ra ();
   uart_pingpong_engine_if #(.DATA_WIDTH(8)) if_ib ();
   uart_pingpong_engine_if #(.DATA_WIDTH(8)) if_rb ();
   uart_pingpong_engine_if #(.DATA_WIDTH(8)) if_ic ();
   uart_pingpong_engine_if #(.DATA_WIDTH(8)) if_rc ();

   uart_pingpong_engine #(.ROLE(0)) u_ia (
      .CLK(clk), .RST(rst_a), .START(start_a), .uart(if_ia), .BUSY(busy[0]), .DONE(done[0]),
      .PASS(pass[0]), .TIMED_OUT(tout[0]), .ERR_CNT(err[0]), .XFER_CNT(xfer[0]));
   uart_pingpong_engine #(.ROLE(1)) u_ra (
      .CLK(clk), .RST(rst_a), .START(start_a), .uart(if_ra), .BUSY(busy[1]), .DONE(done[1]),
      .PASS(pass[1]), .TIMED_OUT(tout[1]), .ERR_CNT(err[1]), .XFER_CNT(xfer[1]));
   uart_pingpong_engine #(.ROLE(0), .START_VAL(8'hFE), .NUM_XFER(3)) u_ib (
      .CLK(clk), .RST(rst_b), .START(start_b), .uart(if_ib), .BUSY(busy[2]), .DONE(done[2]),
      .PASS(pass[2]), .TIMED_OUT(tout[2]), .ERR_CNT(err[2]), .XFER_CNT(xfer[2]));
   uart_pingpong_engine #(.ROLE(1), .START_VAL(8'hFE), .NUM_XFER(3)) u_rb (
      .CLK(clk), .RST(rst_b), .START(start_b), .uart(if_rb), .BUSY(busy[3]), .DONE(done[3]),
      .PASS(pass[3]), .TIMED_OUT(tout[3]), .ERR_CNT(err[3]), .XFER_CNT(xfer[3]));
   uart_pingpong_engine #(.ROLE(0), .TIMEOUT(50)) u_ic (
      .CLK(clk), .RST(rst_c), .START(start_c), .uart(if_ic), .BUSY(busy[4]), .DONE(done[4]),
      .PASS(pass[4]), .TIMED_OUT(tout[4]), .ERR_CNT(err[4]), .XFER_CNT(xfer[4]));
   uart_pingpong_engine #(.ROLE(1), .TIMEOUT(50)) u_rc (
      .CLK(clk), .RST(1'b1), .START(1'b0), .uart(if_rc), .BUSY(busy[5]), .DONE(done[5]),
      .PASS(pass[5]), .TIMED_OUT(tout[5]), .ERR_CNT(err[5]), .XFER_CNT(xfer[5]));

   // Loopback delay lines: {we, data}, 10 stages per direction.
   logic [8:0] dl_a_i2r [10];
   logic [8:0] dl_a_r2i [10];
   logic [8:0] dl_b_i2r [10];
   logic [8:0] dl_b_r2i [10];
   logic [7:0] dcnt;

   always @(posedge clk) begin
      if (rst_a) begin
         for (int i = 0; i < 10; i++) begin
            dl_a_i2r[i] <= '0;
            dl_a_r2i[i] <= '0;
         end
         dcnt <= '0;
      end else begin
         dl_a_i2r[0] <= {if_ia.TX_WE, if_ia.TX_DATA};
         dl_a_r2i[0] <= {if_ra.TX_WE, if_ra.TX_DATA};
         for (int i = 1; i < 10; i++) begin
            dl_a_i2r[i] <= dl_a_i2r[i-1];
            dl_a_r2i[i] <= dl_a_r2i[i-1];
         end
         if (dl_a_i2r[9][8]) dcnt <= dcnt + 8'd1;
      end
   end

   always @(posedge clk) begin
      if (rst_b) begin
         for (int i = 0; i < 10; i++) begin
            dl_b_i2r[i] <= '0;
            dl_b_r2i[i] <= '0;
         end
      end else begin
         dl_b_i2r[0] <= {if_ib.TX_WE, if_ib.TX_DATA};
         dl_b_r2i[0] <= {if_rb.TX_WE, if_rb.TX_DATA};
         for (int i = 1; i < 10; i++) begin
            dl_b_i2r[i] <= dl_b_i2r[i-1];
            dl_b_r2i[i] <= dl_b_r2i[i-1];
         end
      end
   end

   assign if_ia.TX_READY = rdy_a_i;
   assign if_ia.RX_EN    = dl_a_r2i[9][8] | inj;
   assign if_ia.RX_DATA  = dl_a_r2i[9][7:0];
   assign if_ra.TX_READY = 1'b1;
   assign if_ra.RX_EN    = dl_a_i2r[9][8];
   assign if_ra.RX_DATA  = dl_a_i2r[9][7:0] ^ {7'd0, corrupt && (dcnt == 8'd2)};
   assign if_ib.TX_READY = 1'b1;
   assign if_ib.RX_EN    = dl_b_r2i[9][8];
   assign if_ib.RX_DATA  = dl_b_r2i[9][7:0];
   assign if_rb.TX_READY = 1'b1;
   assign if_rb.RX_EN    = dl_b_i2r[9][8];
   assign if_rb.RX_DATA  = dl_b_i2r[9][7:0];
   assign if_ic.TX_READY = 1'b1;
   assign if_ic.RX_EN    = if_rc.TX_WE;
   assign if_ic.RX_DATA  = if_rc.TX_DATA;
   assign if_rc.TX_READY = 1'b1;
   assign if_rc.RX_EN    = if_ic.TX_WE;
   assign if_rc.RX_DATA  = if_ic.TX_DATA;

   int vecs = 0;
   int miss = 0;
   logic [7:0] qa_i[$], qa_r[$], qb_i[$], qb_r[$], qc_i[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [7:0] data);
      vecs++;
      miss++;
      $display("FAIL %s: unexpected TX_WE with data %0h, nothing expected", name, data);
   endtask

   function automatic logic [35:0] st(input int k);
      return {busy[k], done[k], pass[k], tout[k], err[k], xfer[k]};
   endfunction

   function automatic logic [35:0] exp_st(input bit b, input bit d, input bit p, input bit t,
                                          input logic [15:0] e, input logic [15:0] x);
      return {b, d, p, t, e, x};
   endfunction

   task automatic push_basic();
      for (int i = 0; i < 16; i++) begin
         qa_i.push_back(8'h61 + 8'(2 * i));
         qa_r.push_back(8'h62 + 8'(2 * i));
      end
   endtask

   task automatic wait_done(input int k0, input int k1, input int budget, input string name);
      int n = 0;
      while (!(done[k0] && done[k1]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, " reached DONE"}, {63'd0, done[k0] && done[k1]}, 64'd1);
   endtask

   task automatic wait_xfer(input int k, input logic [15:0] val, input int budget,
                            input string name);
      int n = 0;
      while (xfer[k] != val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, " reached XFER_CNT"}, {48'd0, xfer[k]}, {48'd0, val});
   endtask

   task automatic pulse_rst_a();
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   initial begin
      int n;
      // Scoreboard monitor: pop and compare on every TX_WE strobe.
      fork
         forever begin
            @(negedge clk);
            if (if_ia.TX_WE) begin
               if (qa_i.size() == 0) unexpected("A.init tx", if_ia.TX_DATA);
               else check("A.init tx", {56'd0, if_ia.TX_DATA}, {56'd0, qa_i.pop_front()});
            end
            if (if_ra.TX_WE) begin
               if (qa_r.size() == 0) unexpected("A.resp tx", if_ra.TX_DATA);
               else check("A.resp tx", {56'd0, if_ra.TX_DATA}, {56'd0, qa_r.pop_front()});
            end
            if (if_ib.TX_WE) begin
               if (qb_i.size() == 0) unexpected("B.init tx", if_ib.TX_DATA);
               else check("B.init tx", {56'd0, if_ib.TX_DATA}, {56'd0, qb_i.pop_front()});
            end
            if (if_rb.TX_WE) begin
               if (qb_r.size() == 0) unexpected("B.resp tx", if_rb.TX_DATA);
               else check("B.resp tx", {56'd0, if_rb.TX_DATA}, {56'd0, qb_r.pop_front()});
            end
            if (if_ic.TX_WE) begin
               if (qc_i.size() == 0) unexpected("C.init tx", if_ic.TX_DATA);
               else check("C.init tx", {56'd0, if_ic.TX_DATA}, {56'd0, qc_i.pop_front()});
            end
            if (if_rc.TX_WE) unexpected("C.resp tx", if_rc.TX_DATA);
         end
      join_none

      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      @(negedge clk);
      check("A.init reset", {st(0), if_ia.TX_WE, if_ia.TX_DATA}, 64'd0);
      check("A.resp reset", {st(1), if_ra.TX_WE, if_ra.TX_DATA}, 64'd0);

      // Basic exchange with start latency
      push_basic();
      pulse_start_a();
      check("A.init start+1", {62'd0, if_ia.TX_WE, busy[0]}, 64'd1);
      @(negedge clk);
      check("A.init start+2", {55'd0, if_ia.TX_WE, if_ia.TX_DATA}, {55'd0, 1'b1, 8'h61});
      wait_done(0, 1, 3000, "A basic");
      check("A.init basic end", {st(0), if_ia.TX_DATA}, {exp_st(0, 1, 1, 0, 0, 16), 8'h7F});
      check("A.resp basic end", {st(1), if_ra.TX_DATA}, {exp_st(0, 1, 1, 0, 0, 16), 8'h80});
      check("A basic queues drained", 64'(qa_i.size() + qa_r.size()), 64'd0);

      // Corrupt bit0 of the third word delivered to the responder
      pulse_rst_a();
      corrupt = 1'b1;
      for (int i = 0; i < 16; i++) begin
         qa_i.push_back((i < 3) ? 8'h61 + 8'(2 * i) : 8'h66 + 8'(2 * (i - 3)));
         qa_r.push_back((i < 2) ? 8'h62 + 8'(2 * i) : 8'h65 + 8'(2 * (i - 2)));
      end
      pulse_start_a();
      wait_done(0, 1, 3000, "A corrupt");
      corrupt = 1'b0;
      check("A.resp corrupt end", {st(1), if_ra.TX_DATA}, {exp_st(0, 1, 0, 0, 1, 16), 8'h7F});
      check("A.init corrupt end", {st(0), if_ia.TX_DATA}, {exp_st(0, 1, 0, 0, 1, 16), 8'h7E});

      // Backpressure on the initiator plus an overrun strobe while it waits in SEND
      pulse_rst_a();
      rdy_a_i = 1'b0;
      push_basic();
      pulse_start_a();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         inj = (i == 5);
         @(negedge clk);
         if (if_ia.TX_WE) n++;
      end
      inj = 1'b0;
      check("A.init held while not ready", 64'(n), 64'd0);
      check("A.init overrun", {st(0)}, {exp_st(1, 0, 0, 0, 1, 0)});
      rdy_a_i = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (if_ia.TX_WE) n++;
      end
      check("A.init single pulse", 64'(n), 64'd1);
      wait_done(0, 1, 3000, "A backpressure");
      check("A.init overrun end", st(0), exp_st(0, 1, 0, 0, 1, 16));
      check("A.resp overrun end", st(1), exp_st(0, 1, 1, 0, 0, 16));

      // Reset mid-run after five initiator words
      pulse_rst_a();
      for (int i = 0; i < 5; i++) qa_i.push_back(8'h61 + 8'(2 * i));
      for (int i = 0; i < 4; i++) qa_r.push_back(8'h62 + 8'(2 * i));
      pulse_start_a();
      wait_xfer(0, 16'd5, 1000, "A mid-run");
      check("A.init busy mid-run", {63'd0, busy[0]}, 64'd1);
      pulse_rst_a();
      check("A.init mid reset", {st(0), if_ia.TX_WE, if_ia.TX_DATA}, 64'd0);
      check("A.resp mid reset", {st(1), if_ra.TX_WE, if_ra.TX_DATA}, 64'd0);
      repeat (20) @(negedge clk);
      check("A mid-run queues drained", 64'(qa_i.size() + qa_r.size()), 64'd0);
      push_basic();
      pulse_start_a();
      wait_done(0, 1, 3000, "A restart");
      check("A.init restart end", st(0), exp_st(0, 1, 1, 0, 0, 16));
      check("A.resp restart end", st(1), exp_st(0, 1, 1, 0, 0, 16));

      // Wrap-around through 8'hFF
      qb_i = '{8'hFE, 8'h00, 8'h02};
      qb_r = '{8'hFF, 8'h01, 8'h03};
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_done(2, 3, 1000, "B wrap");
      check("B.init wrap end", {st(2), if_ib.TX_DATA}, {exp_st(0, 1, 1, 0, 0, 3), 8'h02});
      check("B.resp wrap end", {st(3), if_rb.TX_DATA}, {exp_st(0, 1, 1, 0, 0, 3), 8'h03});
      check("B queues drained", 64'(qb_i.size() + qb_r.size()), 64'd0);

      // Timeout with the responder held in reset
      qc_i.push_back(8'h61);
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      wait_xfer(4, 16'd1, 100, "C first word");
      n = 0;
      while (!done[4] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("C timeout latency", 64'(n), 64'd50);
      check("C.init timeout end", st(4), exp_st(0, 1, 0, 1, 0, 1));
      check("C queue drained", 64'(qc_i.size()), 64'd0);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/uart_pingpong_engine.md
Name: uart_pingpong_engine

Overview:
Parametrised traffic engine for a UART link. It drives a UartTx-style write port and consumes a UartRx-style receive port. Two instances, one per link end (INITIATOR and RESPONDER), exchange an incrementing word sequence, check every echo, detect timeouts and report pass/fail. It generalises the fixed 8-bit, endless, unchecked ping-pong to a configurable width, transfer count, start value and timeout, with error reporting.

Parameters:
DATA_WIDTH, 8, width of TX_DATA/RX_DATA; all arithmetic is modulo 2^DATA_WIDTH
ROLE, 0, 0 = INITIATOR (sends first word), 1 = RESPONDER (waits for first word)
START_VAL, 8'h61, first word sent by the INITIATOR and first word expected by the RESPONDER
NUM_XFER, 16, words this side sends before DONE; legal range 1..65535
TIMEOUT, 100000, max CLK cycles spent in WAIT_RX; 0 disables the timeout

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; arms the engine from IDLE, ignored in other states
TX_DATA  out  DATA_WIDTH  word to transmit; valid while TX_WE=1, held afterwards
TX_WE  out  1  one-cycle transmit strobe
TX_READY  in  1  transmitter can accept a word
RX_DATA  in  DATA_WIDTH  received word, valid when RX_EN=1
RX_EN  in  1  one-cycle receive strobe
BUSY  out  1  high in SEND and WAIT_RX
DONE  out  1  sticky high in DONE state
PASS  out  1  valid while DONE=1; 1 iff ERR_CNT==0 and no timeout occurred
TIMED_OUT  out  1  sticky; set when a timeout ends the run
ERR_CNT  out  16  mismatch/overrun count, saturates at 16'hFFFF
XFER_CNT  out  16  words sent so far

Behaviour:
- Reset (RST=1 at a CLK edge, from any state including mid-transfer): state=IDLE; TX_DATA=0, TX_WE=0, BUSY=0, DONE=0, PASS=0, TIMED_OUT=0, ERR_CNT=0, XFER_CNT=0; internal last_sent=0, expected=START_VAL, timer=0.
- States: IDLE, SEND, WAIT_RX, DONE.
- IDLE + START: INITIATOR loads pending=START_VAL and goes to SEND. RESPONDER sets expected=START_VAL and goes to WAIT_RX.
- SEND: TX_WE=0 while TX_READY=0. On the first cycle with TX_READY=1, TX_WE and TX_DATA=pending are registered for exactly one cycle. On that same edge: last_sent=pending, XFER_CNT+1, expected=pending+1.
  - INITIATOR always goes to WAIT_RX next.
  - RESPONDER goes to DONE if the incremented XFER_CNT==NUM_XFER, else to WAIT_RX.
- WAIT_RX, on RX_EN=1:
  - If RX_DATA != expected: ERR_CNT+1 (saturating).
  - INITIATOR: if XFER_CNT==NUM_XFER go to DONE; else pending=RX_DATA+1 and go to SEND.
  - RESPONDER: pending=RX_DATA+1, go to SEND.
  - A mismatch resyncs to the received value; there is no retransmit.
- Timer: cleared on entry to WAIT_RX, increments each WAIT_RX cycle without RX_EN. If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no RX_EN, the next state is DONE and TIMED_OUT=1. RX_EN in the same cycle wins over the timeout.
- RX_EN while in SEND (overrun): ERR_CNT+1, word discarded. RX_EN in IDLE or DONE: ignored, not counted.
- DONE: DONE=1, PASS=(ERR_CNT==0 && !TIMED_OUT). Held until RST; START is ignored.
- BUSY is combinational from the state; all other outputs are registered.
- Wrap-around: with DATA_WIDTH=8, 8'hFF+1=8'h00 in both pending and expected, and this is not an error.
- Latency: START to first TX_WE = 2 cycles if TX_READY is already high. RX_EN to the reply TX_WE = 2 cycles if TX_READY is high.

Test Plan:
- Bench: two instances (ROLE 0 and 1) cross-connected through a loopback model that asserts RX_EN 10 cycles after the peer's TX_WE. TX_READY is held at 1 unless a scenario says otherwise.
- Basic: defaults, START both -> INITIATOR sends 61,63,65...; RESPONDER sends 62,64,...; both reach DONE with PASS=1, ERR_CNT=0 and XFER_CNT=16. Initiator's last word is 0x7F, responder's last reply is 0x80.
- Wrap: START_VAL=8'hFE, NUM_XFER=3 -> INITIATOR sends FE,00,02; RESPONDER sends FF,01,03; PASS=1 on both.
- Corruption: loopback flips bit0 of the 3rd word delivered to the RESPONDER -> RESPONDER ERR_CNT=1 and PASS=0; exchange continues from the corrupted value and both sides reach DONE.
- Timeout: TIMEOUT=50, RESPONDER held in reset -> INITIATOR sends 61, then exactly 50 cycles after entering WAIT_RX reaches DONE with TIMED_OUT=1, PASS=0, XFER_CNT=1.
- Backpressure and overrun: TX_READY low for 20 cycles during SEND -> TX_WE stays 0, then a single pulse. Inject RX_EN during SEND -> ERR_CNT+1.
- Reset mid-run: assert RST for 1 cycle while in WAIT_RX after 5 transfers -> all outputs return to reset values the next cycle and START restarts from START_VAL.
